alu_srca_seq: RTL and testbench

//  Multi-cycle sequencer for the ALU source-A operand select. It computes

---
 rtl/alu_srca_seq.sv | 114 +++++++++++
 tb/tb_alu_srca_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_srca_seq.sv
// alu_srca_seq: multi-cycle sequencer for the ALU source-A operand select.
// Computes result = init + count*srcA (mod 2^W) by driving sel_srca and the
// accumulator to the ALU for count cycles and capturing alu_result each cycle.
// Optional feature macro: ALU_SRCA_SEQ_OVF_EN (adds alu_ovf input, sticky ovf output).

module alu_srca_seq #(
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 8
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [W-1:0]  init,
   input  logic [CW-1:0] count,
   input  logic [W-1:0]  alu_result,
`ifdef ALU_SRCA_SEQ_OVF_EN
   input  logic          alu_ovf,
   output logic          ovf,
`endif
   output logic [1:0]    sel_srca,
   output logic [W-1:0]  alu_b,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
`ifdef ALU_SRCA_SEQ_OVF_EN
   logic          ovf_q, ovf_d;
`endif

   // Next-state, datapath updates and decoded outputs.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sel_srca = 2'b00;
      done     = 1'b0;
`ifdef ALU_SRCA_SEQ_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_d    = op;
               acc_d   = init;
               cnt_d   = count;
`ifdef ALU_SRCA_SEQ_OVF_EN
               ovf_d   = 1'b0;
`endif
               // A zero count skips RUN entirely; result is just init.
               state_d = (count == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            sel_srca = op_q;
            acc_d    = alu_result;
            cnt_d    = cnt_q - CW'(1);
`ifdef ALU_SRCA_SEQ_OVF_EN
            ovf_d    = ovf_q | alu_ovf;
`endif
            if (cnt_q == CW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register; reset aborts any run without a done pulse.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= 2'b00;
`ifdef ALU_SRCA_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
`ifdef ALU_SRCA_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Registered values straight to the outputs.
   always_comb begin
      alu_b  = acc_q;
      result = acc_q;
      busy   = (state_q != StIdle);
`ifdef ALU_SRCA_SEQ_OVF_EN
      ovf    = ovf_q;
`endif
   end

endmodule

// File: tb/tb_alu_srca_seq.sv
// tb_alu_srca_seq: directed self-checking bench for alu_srca_seq with a
// behavioural ALU model and a queue scoreboard of expected results.
// Build with ALU_SRCA_SEQ_OVF_EN defined to exercise the overflow flag.

module tb_alu_srca_seq;

   logic       CLK = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] op;
   logic [7:0] init;
   logic [7:0] count;
   logic [7:0] alu_result;
   logic [1:0] sel_srca;
   logic [7:0] alu_b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       alu_ovf;
`ifdef ALU_SRCA_SEQ_OVF_EN
   logic       ovf;
`endif

   logic [7:0] a_val;
   logic [7:0] srca;
   logic [7:0] exp_q[$];
   int         total = 0;
   int         bad   = 0;

   alu_srca_seq #(.W(8), .CW(8)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .init       (init),
      .count      (count),
      .alu_result (alu_result),
`ifdef ALU_SRCA_SEQ_OVF_EN
      .alu_ovf    (alu_ovf),
      .ovf        (ovf),
`endif
      .sel_srca   (sel_srca),
      .alu_b      (alu_b),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 CLK = ~CLK;

   // ALU model: srcA + alu_b with signed-overflow flag.
   always_comb begin
      case (sel_srca)
         2'b00:   srca = 8'h01;
         2'b01:   srca = 8'hFF;
         2'b10:   srca = a_val;
         default: srca = 8'h00 - a_val;
      endcase
      alu_result = srca + alu_b;
      alu_ovf    = (srca[7] == alu_b[7]) && (alu_result[7] != srca[7]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One run: accept at edge k, expect done after edge k+cnt, check run
   // shape, scoreboard result, and that result holds once back in IDLE.
   task automatic do_run(input string tag, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] ini, input logic [7:0] cnt,
                         input logic [7:0] exp, input logic exp_ovf, input bit poke);
      int n = 0;
      int runc = 0;
      int busyc = 0;
      int selbad = 0;
      int done_n = -1;
      logic [7:0] want;
      @(negedge CLK);
      op = o; a_val = a; init = ini; count = cnt; start = 1'b1;
      exp_q.push_back(exp);
      @(posedge CLK);
      #1 start = 1'b0;
      while (done_n < 0 && n < 300) begin
         @(negedge CLK);
         if (poke && n == 1) begin
            start = 1'b1; op = ~o; init = 8'h55;
         end else begin
            start = 1'b0; op = o; init = ini;
         end
         if (busy) busyc++;
         if (busy && !done) begin
            runc++;
            if (sel_srca !== o) selbad++;
         end
         if (!busy && sel_srca !== 2'b00) selbad++;
         if (done) done_n = n;
         else n++;
      end
      start = 1'b0;
      chk({tag, "_done_latency"}, 32'(done_n), 32'(cnt));
      chk({tag, "_run_cycles"}, 32'(runc), 32'(cnt));
      chk({tag, "_busy_cycles"}, 32'(busyc), 32'(cnt) + 1);
      chk({tag, "_sel_srca"}, 32'(selbad), 32'd0);
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         chk({tag, "_result"}, 32'(result), 32'(want));
      end else begin
         chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
      end
`ifdef ALU_SRCA_SEQ_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
      if (exp_ovf !== 1'bx) ; // flag only observable with the overflow build
`endif
      @(negedge CLK);
      chk({tag, "_idle_after"}, {29'd0, busy, done, 1'b0}, 32'd0);
      chk({tag, "_result_hold"}, 32'(result), 32'(exp));
   endtask

   initial begin
      int quiet;
      reset = 1'b1; start = 1'b0; op = 2'b00; init = 8'h00; count = 8'h00; a_val = 8'h00;
      #12;
      chk("reset_state", {sel_srca, alu_b, busy, done, result}, 32'd0);
      @(negedge CLK); reset = 1'b0;

      // Test 2: repeated add
      do_run("add3x5", 2'b10, 8'h03, 8'h00, 8'd5, 8'h0F, 1'b0, 1'b0);
      // Test 3: zero count
      do_run("cnt0", 2'b00, 8'h00, 8'h42, 8'd0, 8'h42, 1'b0, 1'b0);
      // Test 4: decrement wrap and negative A
      do_run("dec_wrap", 2'b01, 8'h00, 8'h02, 8'd4, 8'hFE, 1'b0, 1'b0);
      do_run("neg_a", 2'b11, 8'h02, 8'h10, 8'd3, 8'h0A, 1'b0, 1'b0);
      do_run("inc", 2'b00, 8'h00, 8'hFD, 8'd6, 8'h03, 1'b0, 1'b0);
      // Test 5: start during RUN ignored
      do_run("poke", 2'b10, 8'h03, 8'h00, 8'd4, 8'h0C, 1'b0, 1'b1);

      // Test 1/5: asynchronous reset mid-run
      @(negedge CLK);
      op = 2'b10; a_val = 8'h05; init = 8'h20; count = 8'd6; start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
      @(posedge CLK); @(posedge CLK);
      #2 reset = 1'b1;
      #1;
      chk("reset_mid_run", {sel_srca, alu_b, busy, done, result}, 32'd0);
      @(negedge CLK); reset = 1'b0;
      quiet = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (done || busy) quiet++;
      end
      chk("no_done_after_reset", 32'(quiet), 32'd0);
      do_run("after_reset", 2'b10, 8'h07, 8'h01, 8'd2, 8'h0F, 1'b0, 1'b0);

      // Test 6: overflow flag (checked only in the overflow build)
      do_run("ovf_set", 2'b10, 8'h40, 8'h00, 8'd2, 8'h80, 1'b1, 1'b0);
      do_run("ovf_clr", 2'b10, 8'h01, 8'h00, 8'd1, 8'h01, 1'b0, 1'b0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
